// File: rtl/reg_bus_arbiter_pkg.sv
// Shared types and defaults for the two-requester register bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package reg_bus_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned RSVD_DEF   = 0;

  // Bus access sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_RD_SETUP = 3'd2,
    ST_RD_CAP   = 3'd3,
    ST_ACK      = 3'd4
  } state_e;

  // Arbitration result: vld = someone is requesting, port = winning index
  typedef struct packed {
    logic vld;
    logic port;
  } grant_t;

  // Two-way round robin: a lone requester wins; on a tie the port that did
  // not win last time wins now.
  function automatic grant_t rr_pick(input logic req0, input logic req1,
                                     input logic last_grant);
    grant_t g;
    g.vld  = req0 | req1;
    g.port = (req0 & req1) ? ~last_grant : req1;
    return g;
  endfunction

endpackage

// File: rtl/reg_bus_rr_arb2.sv
// Combinational 2-way round-robin pick between req0 and req1.
// Latency: zero cycles, purely combinational.
// Backpressure: none; the caller decides when the grant is consumed.
module reg_bus_rr_arb2
  import reg_bus_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant,
  output logic valid
);

  grant_t pick;

  // Resolve the winner from the live requests and the previous grant
  always_comb begin
    pick  = rr_pick(req0, req1, last_grant);
    grant = pick.port;
    valid = pick.vld;
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// Shares the register bus between two requesters, one FSM-sequenced access at a time.
// Latency: ack at k+2 for writes, k+3 for reads, k+1 for reserved-address rejects.
// Backpressure: requesters hold req until their one-cycle ack; the loser of a tie waits one transaction.
module reg_bus_arbiter
  import reg_bus_arbiter_pkg::*;
#(
  parameter int unsigned        ADDR_W = ADDR_W_DEF,
  parameter int unsigned        DATA_W = DATA_W_DEF,
  parameter logic [ADDR_W-1:0]  RSVD   = ADDR_W'(RSVD_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_wr,
  inout  wire  [DATA_W-1:0] reg_data
);

  state_e            state_q, state_d;
  logic              last_grant_q;
  logic              port_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grant;
  logic              grant_vld;
  logic              take;
  logic              win_wr;
  logic              win_rsvd;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              drive_en;

  reg_bus_rr_arb2 u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .grant      (grant),
    .valid      (grant_vld)
  );

  // A new transaction is accepted only from IDLE, which also guarantees an
  // idle bus cycle between any two accesses.
  assign take = (state_q == ST_IDLE) && grant_vld;

  // Route the winning requester's fields to the latch inputs
  always_comb begin
    win_wr    = grant ? wr1    : wr0;
    win_addr  = grant ? addr1  : addr0;
    win_wdata = grant ? wdata1 : wdata0;
    win_rsvd  = (win_addr == RSVD);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and bus/handshake outputs; the bus idles at RSVD with no strobe
  always_comb begin
    state_d  = state_q;
    reg_addr = RSVD;
    reg_wr   = 1'b0;
    drive_en = 1'b0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    err      = 1'b0;
    busy     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (grant_vld) begin
          if (win_rsvd) begin
            state_d = ST_ACK;
          end else if (win_wr) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD_SETUP;
          end
        end
      end
      ST_WR: begin
        reg_addr = addr_q;
        reg_wr   = 1'b1;
        drive_en = 1'b1;
        state_d  = ST_ACK;
      end
      ST_RD_SETUP: begin
        reg_addr = addr_q;
        state_d  = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        reg_addr = addr_q;
        state_d  = ST_ACK;
      end
      ST_ACK: begin
        ack0    = ~port_q;
        ack1    = port_q;
        err     = err_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Latch the winner's request so later changes on its inputs are ignored
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      err_q        <= 1'b0;
      addr_q       <= RSVD;
      wdata_q      <= '0;
    end else if (take) begin
      last_grant_q <= grant;
      port_q       <= grant;
      err_q        <= win_rsvd;
      addr_q       <= win_addr;
      wdata_q      <= win_wdata;
    end
  end

  // Read result: cleared by a reserved-address reject, captured at the end
  // of RD_CAP, untouched by writes
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (take && win_rsvd) begin
      rdata_q <= '0;
    end else if (state_q == ST_RD_CAP) begin
      rdata_q <= reg_data;
    end
  end

  assign rdata = rdata_q;

  // Master drives data only during the single WR cycle
  assign reg_data = drive_en ? wdata_q : {DATA_W{1'bz}};

  // Only one requester is acknowledged per transaction
  a_one_ack : assert property (@(posedge clk) disable iff (reset) !(ack0 && ack1));

  // Write strobes never occur in consecutive cycles
  a_wr_single : assert property (@(posedge clk) disable iff (reset) reg_wr |=> !reg_wr);

  // The rejection flag is only ever presented alongside an ack
  a_err_with_ack : assert property (@(posedge clk) disable iff (reset) err |-> (ack0 || ack1));

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Bench for reg_bus_arbiter: register-file model on the bus plus an ack scoreboard.
// Latency: expected ack cycles are hand-computed per transaction.
// Backpressure: requesters hold req until ack; ties exercise the wait path.
module tb_reg_bus_arbiter;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic              req0, req1, wr0, wr1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              ack0, ack1, err, busy, reg_wr;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] reg_addr;
  wire  [DATA_W-1:0] reg_data;

  reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RSVD(16'h0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .req0     (req0),
    .req1     (req1),
    .wr0      (wr0),
    .wr1      (wr1),
    .addr0    (addr0),
    .addr1    (addr1),
    .wdata0   (wdata0),
    .wdata1   (wdata1),
    .ack0     (ack0),
    .ack1     (ack1),
    .err      (err),
    .rdata    (rdata),
    .busy     (busy),
    .reg_addr (reg_addr),
    .reg_wr   (reg_wr),
    .reg_data (reg_data)
  );

  always #5 clk = ~clk;

  // ---------------- register file model (addresses 0..15, counter at 7)
  logic [DATA_W-1:0] regs [0:15];
  logic              mdl_clr;
  logic              cnt_inc;
  logic [DATA_W-1:0] mdl_val;

  always @(posedge clk) begin
    if (mdl_clr) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h1000_0000 + i;
    end else if (reg_wr && reg_addr < 16'd16) begin
      regs[reg_addr[3:0]] <= reg_data;
    end else if (cnt_inc) begin
      regs[7] <= regs[7] + 32'd1;
    end
  end

  always_comb begin
    mdl_val = (reg_addr < 16'd16) ? regs[reg_addr[3:0]]
                                  : (32'hBAD0_0000 | {16'h0000, reg_addr});
  end

  // Registers drive the bus whenever the master is not writing
  assign reg_data = reg_wr ? {DATA_W{1'bz}} : mdl_val;

  // ---------------- bookkeeping
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ack_total = 0;
  int wr_cycles = 0;
  int bus_bad = 0;
  logic [ADDR_W-1:0] last_wr_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bus watcher: count write strobes; when the master is not writing the bus
  // must carry exactly what the register model drives (no master contention)
  always @(negedge clk) begin
    if (reg_wr) begin
      wr_cycles++;
      last_wr_addr = reg_addr;
    end else if (reg_data !== mdl_val) begin
      bus_bad++;
    end
  end

  // ---------------- scoreboard
  typedef struct {
    int          id;
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sbq[$];

  task automatic push(input int id, input logic port, input logic e,
                      input logic [31:0] rd, input int c);
    exp_t x;
    x.id = id; x.port = port; x.err = e; x.rdata = rd; x.cyc = c;
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ack0 || ack1) begin
      ack_total++;
      if (sbq.size() == 0) begin
        chk("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk($sformatf("t%0d_port", e.id), {30'b0, ack1, ack0}, e.port ? 32'd2 : 32'd1);
        chk($sformatf("t%0d_err", e.id), {31'b0, err}, {31'b0, e.err});
        chk($sformatf("t%0d_rdata", e.id), rdata, e.rdata);
        chk($sformatf("t%0d_ack_cycle", e.id), cyc, e.cyc);
      end
    end
  end

  // ---------------- stimulus helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise req on one port, wait for n acks (bounded), then drop req
  task automatic txn(input logic port, input logic wr, input logic [15:0] a,
                     input logic [31:0] wd, input int n);
    int got = 0;
    if (port) begin req1 = 1'b1; wr1 = wr; addr1 = a; wdata1 = wd; end
    else      begin req0 = 1'b1; wr0 = wr; addr0 = a; wdata0 = wd; end
    for (int i = 0; i < 40 && got < n; i++) begin
      @(negedge clk);
      if (port ? ack1 : ack0) got++;
    end
    chk($sformatf("ack_count_p%0d", port), got, n);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- directed vectors
  initial begin
    int k;
    int wrb;
    int ab;
    reset = 1'b1; mdl_clr = 1'b1; cnt_inc = 1'b0;
    req0 = 1'b0; req1 = 1'b0; wr0 = 1'b0; wr1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    step(); step();
    @(negedge clk);
    chk("rst_reg_addr", {16'h0, reg_addr}, 32'd0);
    chk("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ack", {30'b0, ack1, ack0}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    step();
    reset = 1'b0; mdl_clr = 1'b0;

    // 1: write DEADBEEF to 5 from port 0, ack at k+2
    step();
    k = cyc; wrb = wr_cycles;
    push(1, 1'b0, 1'b0, 32'd0, k + 2);
    txn(1'b0, 1'b1, 16'd5, 32'hDEAD_BEEF, 1);
    chk("t1_wr_strobes", wr_cycles - wrb, 32'd1);
    chk("t1_wr_addr", {16'h0, last_wr_addr}, 32'd5);
    chk("t1_reg5", regs[5], 32'hDEAD_BEEF);

    // 2: read 5 from port 1, ack at k+3
    step();
    k = cyc;
    push(2, 1'b1, 1'b0, 32'hDEAD_BEEF, k + 3);
    txn(1'b1, 1'b0, 16'd5, 32'd0, 1);

    // 4: reserved-address read and write, ack at k+1, err, rdata cleared
    step();
    k = cyc; wrb = wr_cycles;
    push(3, 1'b0, 1'b1, 32'd0, k + 1);
    txn(1'b0, 1'b0, 16'd0, 32'd0, 1);
    step();
    k = cyc;
    push(4, 1'b1, 1'b1, 32'd0, k + 1);
    txn(1'b1, 1'b1, 16'd0, 32'h1234_5678, 1);
    chk("t4_no_strobe", wr_cycles - wrb, 32'd0);

    // Reset so the next tie resolves from the reset grant history
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;

    // 3: two ties of writes; port 0 wins both times
    step();
    k = cyc;
    push(5, 1'b0, 1'b0, 32'd0, k + 2);
    push(6, 1'b1, 1'b0, 32'd0, k + 5);
    fork
      txn(1'b0, 1'b1, 16'd2, 32'hAAAA_0002, 1);
      txn(1'b1, 1'b1, 16'd3, 32'hBBBB_0003, 1);
    join
    chk("t3_reg2", regs[2], 32'hAAAA_0002);
    chk("t3_reg3", regs[3], 32'hBBBB_0003);
    step();
    k = cyc;
    push(7, 1'b0, 1'b0, 32'd0, k + 2);
    push(8, 1'b1, 1'b0, 32'd0, k + 5);
    fork
      txn(1'b0, 1'b1, 16'd2, 32'h2222_2222, 1);
      txn(1'b1, 1'b1, 16'd3, 32'h3333_3333, 1);
    join
    chk("t3b_reg2", regs[2], 32'h2222_2222);
    chk("t3b_reg3", regs[3], 32'h3333_3333);

    // 5: clear counter at 7, pulse it 10 times, read twice with req held
    step();
    k = cyc;
    push(9, 1'b0, 1'b0, 32'd0, k + 2);
    txn(1'b0, 1'b1, 16'd7, 32'd0, 1);
    cnt_inc = 1'b1;
    repeat (10) step();
    cnt_inc = 1'b0;
    k = cyc;
    push(10, 1'b1, 1'b0, 32'd10, k + 3);
    push(11, 1'b1, 1'b0, 32'd10, k + 7);
    txn(1'b1, 1'b0, 16'd7, 32'd0, 2);

    // 6: reset during RD_SETUP aborts without ack; then a normal read
    step();
    k = cyc;
    req0 = 1'b1; wr0 = 1'b0; addr0 = 16'd5;
    step();
    @(negedge clk);
    chk("t6_setup_busy", {31'b0, busy}, 32'd1);
    chk("t6_setup_addr", {16'h0, reg_addr}, 32'd5);
    ab = ack_total;
    reset = 1'b1; req0 = 1'b0;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t6_busy_after", {31'b0, busy}, 32'd0);
    chk("t6_addr_after", {16'h0, reg_addr}, 32'd0);
    chk("t6_rdata_after", rdata, 32'd0);
    repeat (4) step();
    chk("t6_no_ack", ack_total - ab, 32'd0);
    k = cyc;
    push(12, 1'b0, 1'b0, 32'hDEAD_BEEF, k + 3);
    txn(1'b0, 1'b0, 16'd5, 32'd0, 1);

    repeat (3) step();
    chk("sb_drained", sbq.size(), 32'd0);
    chk("bus_turnaround", bus_bad, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
